// File: rtl/cpu_types_pkg.sv
// Shared CPU-side types and constants.
//   WORD_W         : datapath / memory word width
//   BYTE_OFF_W     : byte-offset bits inside a word
//   icache_state_t : instruction-cache controller states (IDLE, FILL)
package cpu_types_pkg;

    localparam int WORD_W     = 32;
    localparam int BYTE_OFF_W = 2;

    typedef enum logic {
        IDLE = 1'b0,
        FILL = 1'b1
    } icache_state_t;

endpackage

// File: rtl/icache_way.sv
// One way of the set-associative instruction cache.
// Holds per-set valid bit, tag and a full WORDS-word line, and performs
// the tag compare for the addressed set. A whole line is written in one
// cycle once the refill has collected every word, so a line is never
// visible half-written.
// Ports:
//   clk, srst        : clock, synchronous active-high reset (clears valid bits)
//   rd_index/tag/off : lookup set, tag and word-in-block
//   hit, valid       : tag match on a valid line; valid bit of the addressed set
//   rd_data          : addressed word of the addressed set
//   wr_en/index/tag  : install a line (sets valid)
//   wr_line          : full line data, word 0 in the low bits
module icache_way
    import cpu_types_pkg::*;
#(
    parameter int SETS  = 8,
    parameter int WORDS = 2,
    parameter int IDX_W = 3,
    parameter int TAG_W = 26,
    parameter int OFF_W = 1
) (
    input  logic                      clk,
    input  logic                      srst,
    input  logic [IDX_W-1:0]          rd_index,
    input  logic [TAG_W-1:0]          rd_tag,
    input  logic [OFF_W-1:0]          rd_offset,
    output logic                      hit,
    output logic                      valid,
    output logic [WORD_W-1:0]         rd_data,
    input  logic                      wr_en,
    input  logic [IDX_W-1:0]          wr_index,
    input  logic [TAG_W-1:0]          wr_tag,
    input  logic [WORDS*WORD_W-1:0]   wr_line
);

    logic [SETS-1:0]          valid_reg;
    logic [TAG_W-1:0]         tag_mem  [SETS];
    logic [WORDS*WORD_W-1:0]  data_mem [SETS];
    logic [WORD_W-1:0]        line_words [WORDS];

    always_ff @(posedge clk) begin
        if (srst) begin
            valid_reg <= '0;
        end else if (wr_en) begin
            valid_reg[wr_index] <= 1'b1;
        end
    end

    // Tag and data arrays carry no reset; only the valid bits matter.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            tag_mem[wr_index]  <= wr_tag;
            data_mem[wr_index] <= wr_line;
        end
    end

    // Reads are combinational: a hit must be answered in the request cycle.
    assign valid = valid_reg[rd_index];
    assign hit   = valid && (tag_mem[rd_index] == rd_tag);

    genvar gi;
    generate
        for (gi = 0; gi < WORDS; gi++) begin : g_word
            assign line_words[gi] = data_mem[rd_index][gi*WORD_W +: WORD_W];
        end
        if (WORDS > 1) begin : g_multi
            assign rd_data = line_words[rd_offset];
        end else begin : g_single
            assign rd_data = line_words[0];
        end
    endgenerate

endmodule

// File: rtl/icache_assoc.sv
// Set-associative instruction cache between the datapath fetch port and the
// memory-controller instruction port. SETS sets, WAYS ways, WORDS words per
// block; misses refill a whole block word by word, victims chosen as the
// lowest invalid way or else the set's round-robin pointer.
// Fetches are deferred while a data access is pending and suppressed while
// halted; a halt or reset abandons any refill without touching the victim.
// Ports:
//   CLK, RST             : clock, synchronous active-high reset
//   imemREN, imemaddr    : fetch request and byte address
//   dmemREN, dmemWEN     : data access pending (fetch deferred)
//   halt                 : processor halted
//   ihit, imemload       : fetch served this cycle, instruction (0 when no hit)
//   iREN, iaddr          : memory read request and byte address
//   iload, iwait         : memory read data, memory busy
//   hit_count, miss_count: only with ICACHE_STATS_EN defined
module icache_assoc
    import cpu_types_pkg::*;
#(
    parameter int SETS  = 8,
    parameter int WAYS  = 2,
    parameter int WORDS = 2
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        imemREN,
    input  logic [31:0] imemaddr,
    input  logic        dmemREN,
    input  logic        dmemWEN,
    input  logic        halt,
    output logic        ihit,
    output logic [31:0] imemload,
    output logic        iREN,
    output logic [31:0] iaddr,
    input  logic [31:0] iload,
    input  logic        iwait
`ifdef ICACHE_STATS_EN
    ,
    output logic [31:0] hit_count,
    output logic [31:0] miss_count
`endif
);

    localparam int BLK_W  = $clog2(WORDS);
    localparam int IDX_W  = $clog2(SETS);
    localparam int OFF_W  = (WORDS > 1) ? BLK_W : 1;
    localparam int PTR_W  = (WAYS > 1) ? $clog2(WAYS) : 1;
    localparam int IDX_LO = BYTE_OFF_W + BLK_W;
    localparam int TAG_LO = IDX_LO + IDX_W;
    localparam int TAG_W  = WORD_W - TAG_LO;
    localparam int BLK_AW = TAG_W + IDX_W;   // block address: tag + index

    icache_state_t       state_reg;
    logic [BLK_AW-1:0]   blk_addr_reg;
    logic [OFF_W-1:0]    cnt_reg;
    logic [PTR_W-1:0]    victim_reg;
    logic [PTR_W-1:0]    ptr_reg  [SETS];
    logic [WORD_W-1:0]   fill_buf [WORDS];

    logic                req;
    logic [IDX_W-1:0]    look_idx;
    logic [TAG_W-1:0]    look_tag;
    logic [OFF_W-1:0]    look_off;
    logic [IDX_W-1:0]    fill_idx;
    logic [TAG_W-1:0]    fill_tag;
    logic [WAYS-1:0]     way_hit;
    logic [WAYS-1:0]     way_valid;
    logic [WORD_W-1:0]   way_data [WAYS];
    logic [WORD_W-1:0]   hit_data;
    logic [PTR_W-1:0]    victim_sel;
    logic                any_hit;
    logic                miss_start;
    logic                accept;
    logic                fill_done;
    logic [WORDS*WORD_W-1:0] fill_line;
    logic [WORD_W-1:0]   fill_addr;

    assign req      = imemREN && !dmemREN && !dmemWEN && !halt;
    assign look_idx = imemaddr[IDX_LO +: IDX_W];
    assign look_tag = imemaddr[WORD_W-1:TAG_LO];
    assign look_off = (WORDS > 1) ? imemaddr[BYTE_OFF_W +: OFF_W] : '0;
    assign fill_idx = blk_addr_reg[IDX_W-1:0];
    assign fill_tag = blk_addr_reg[BLK_AW-1:IDX_W];

    genvar gi;
    generate
        for (gi = 0; gi < WAYS; gi++) begin : g_way
            icache_way #(
                .SETS  (SETS),
                .WORDS (WORDS),
                .IDX_W (IDX_W),
                .TAG_W (TAG_W),
                .OFF_W (OFF_W)
            ) u_way (
                .clk       (CLK),
                .srst      (RST),
                .rd_index  (look_idx),
                .rd_tag    (look_tag),
                .rd_offset (look_off),
                .hit       (way_hit[gi]),
                .valid     (way_valid[gi]),
                .rd_data   (way_data[gi]),
                .wr_en     (fill_done && (victim_reg == PTR_W'(gi))),
                .wr_index  (fill_idx),
                .wr_tag    (fill_tag),
                .wr_line   (fill_line)
            );
        end

        // The word arriving on the final transfer bypasses the buffer so the
        // line is installed on the same edge it is accepted.
        for (gi = 0; gi < WORDS; gi++) begin : g_fill_line
            assign fill_line[gi*WORD_W +: WORD_W] =
                (cnt_reg == OFF_W'(gi)) ? iload : fill_buf[gi];
        end

        if (WORDS > 1) begin : g_addr_multi
            assign fill_addr = {blk_addr_reg, cnt_reg, {BYTE_OFF_W{1'b0}}};
        end else begin : g_addr_single
            assign fill_addr = {blk_addr_reg, {BYTE_OFF_W{1'b0}}};
        end
    endgenerate

    // At most one way can match, so an OR of the gated way outputs is a mux.
    always_comb begin
        hit_data = '0;
        for (int w = 0; w < WAYS; w++) begin
            if (way_hit[w]) begin
                hit_data = hit_data | way_data[w];
            end
        end
    end

    // Descending scan so the lowest-index invalid way wins.
    always_comb begin
        victim_sel = ptr_reg[look_idx];
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (!way_valid[w]) begin
                victim_sel = PTR_W'(w);
            end
        end
    end

    assign any_hit    = |way_hit;
    assign miss_start = (state_reg == IDLE) && req && !any_hit;
    assign accept     = (state_reg == FILL) && req && !iwait;
    assign fill_done  = accept && (cnt_reg == OFF_W'(WORDS - 1));

    // Outputs are forced quiet during the reset cycle itself.
    assign ihit     = !RST && (state_reg == IDLE) && req && any_hit;
    assign imemload = ihit ? hit_data : '0;
    assign iREN     = !RST && (state_reg == FILL) && req;
    assign iaddr    = (!RST && (state_reg == FILL)) ? fill_addr : '0;

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_reg    <= IDLE;
            blk_addr_reg <= '0;
            cnt_reg      <= '0;
            victim_reg   <= '0;
            for (int s = 0; s < SETS; s++) begin
                ptr_reg[s] <= '0;
            end
        end else begin
            case (state_reg)
                IDLE: begin
                    if (miss_start) begin
                        state_reg    <= FILL;
                        blk_addr_reg <= imemaddr[WORD_W-1:IDX_LO];
                        victim_reg   <= victim_sel;
                        cnt_reg      <= '0;
                    end
                end
                FILL: begin
                    if (halt) begin
                        state_reg <= IDLE;
                    end else if (accept) begin
                        cnt_reg <= cnt_reg + 1'b1;
                        if (fill_done) begin
                            state_reg <= IDLE;
                            ptr_reg[fill_idx] <=
                                (ptr_reg[fill_idx] == PTR_W'(WAYS - 1)) ?
                                '0 : ptr_reg[fill_idx] + 1'b1;
                        end
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    // Refill staging buffer; contents are meaningless outside FILL.
    always_ff @(posedge CLK) begin
        if (accept) begin
            fill_buf[cnt_reg] <= iload;
        end
    end

`ifdef ICACHE_STATS_EN
    always_ff @(posedge CLK) begin
        if (RST) begin
            hit_count  <= '0;
            miss_count <= '0;
        end else begin
            if (ihit) begin
                hit_count <= hit_count + 32'd1;
            end
            if (miss_start) begin
                miss_count <= miss_count + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_icache_assoc.sv
// Directed testbench for icache_assoc with default parameters.
// Memory model: read data equals the requested address; iwait is high for
// one cycle of every word transfer. With ICACHE_STATS_EN defined the
// statistics counters are exercised as well.
module tb_icache_assoc;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        imemREN = 1'b0;
    logic [31:0] imemaddr = 32'h0;
    logic        dmemREN = 1'b0;
    logic        dmemWEN = 1'b0;
    logic        halt = 1'b0;
    logic        ihit;
    logic [31:0] imemload;
    logic        iREN;
    logic [31:0] iaddr;
    logic [31:0] iload;
    logic        iwait = 1'b1;
`ifdef ICACHE_STATS_EN
    logic [31:0] hit_count;
    logic [31:0] miss_count;
`endif

    int n_checks = 0;
    int n_fail   = 0;
    logic [31:0] acc_q[$];

    icache_assoc dut (
        .CLK      (CLK),
        .RST      (RST),
        .imemREN  (imemREN),
        .imemaddr (imemaddr),
        .dmemREN  (dmemREN),
        .dmemWEN  (dmemWEN),
        .halt     (halt),
        .ihit     (ihit),
        .imemload (imemload),
        .iREN     (iREN),
        .iaddr    (iaddr),
        .iload    (iload),
        .iwait    (iwait)
`ifdef ICACHE_STATS_EN
        ,
        .hit_count  (hit_count),
        .miss_count (miss_count)
`endif
    );

    always #5 CLK = ~CLK;

    assign iload = iaddr;

    // Memory responder: one wait cycle, then accept; log every accepted address.
    always @(posedge CLK) begin
        if (iREN && !iwait) begin
            acc_q.push_back(iaddr);
        end
        iwait <= !(iREN && iwait);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    // Present a fetch and wait (bounded) for ihit; cycles = samples before the hit.
    task automatic fetch(input logic [31:0] addr, output int cycles, output logic [31:0] data);
        @(negedge CLK);
        imemaddr = addr;
        imemREN  = 1'b1;
        #1;
        cycles = 0;
        while (!ihit && cycles < 40) begin
            @(negedge CLK);
            #1;
            cycles++;
        end
        data = imemload;
    endtask

    task automatic fetch_check(input logic [31:0] addr, input int exp_lat, input string name);
        int          cyc;
        logic [31:0] d;
        fetch(addr, cyc, d);
        check({name, "_lat"}, 32'(cyc), 32'(exp_lat));
        check({name, "_data"}, d, addr);
    endtask

    // Start a miss and return once its first word has been accepted.
    task automatic start_fill(input logic [31:0] addr);
        @(negedge CLK);
        acc_q.delete();
        imemaddr = addr;
        imemREN  = 1'b1;
        for (int i = 0; i < 20 && acc_q.size() == 0; i++) begin
            @(negedge CLK);
        end
        check("first_word_accepted", 32'(acc_q.size()), 32'd1);
    endtask

    logic [31:0] t2_addr [7] = '{32'h240, 32'h440, 32'h240, 32'h040, 32'h440, 32'h040, 32'h240};
    int          t2_lat  [7] = '{5, 5, 0, 5, 0, 0, 5};

    initial begin
        int cyc;

        // Reset: outputs quiet even with a fetch presented.
        imemREN  = 1'b1;
        imemaddr = 32'h040;
        repeat (2) @(negedge CLK);
        #1;
        check("rst_ihit", 32'(ihit), 32'd0);
        check("rst_imemload", imemload, 32'd0);
        check("rst_iREN", 32'(iREN), 32'd0);
        check("rst_iaddr", iaddr, 32'd0);
        @(negedge CLK);
        RST     = 1'b0;
        imemREN = 1'b0;

        // Cold miss at 0x040: two transfers, hit one cycle later.
        acc_q.delete();
        fetch_check(32'h040, 5, "t1_miss040");
        check("t1_acc_n", 32'(acc_q.size()), 32'd2);
        check("t1_acc0", acc_q[0], 32'h040);
        check("t1_acc1", acc_q[1], 32'h044);
        fetch_check(32'h044, 0, "t1_hit044");
        check("t1_hit_iREN", 32'(iREN), 32'd0);

        // Conflict misses in set 0 with round-robin replacement.
        for (int i = 0; i < 7; i++) begin
            fetch_check(t2_addr[i], t2_lat[i], $sformatf("t2_%0d_%03h", i, t2_addr[i]));
        end

        // Data write pending between fill words stalls the refill.
        start_fill(32'h058);
        dmemWEN = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            check($sformatf("t3_stall_iREN_%0d", i), 32'(iREN), 32'd0);
            @(negedge CLK);
        end
        dmemWEN = 1'b0;
        check("t3_acc_hold", 32'(acc_q.size()), 32'd1);
        #1;
        cyc = 0;
        while (!ihit && cyc < 40) begin
            @(negedge CLK);
            #1;
            cyc++;
        end
        check("t3_ihit", 32'(ihit), 32'd1);
        check("t3_data", imemload, 32'h058);
        check("t3_acc1", acc_q[1], 32'h05c);
        fetch_check(32'h05c, 0, "t3_hit05c");

        // Halt after the first word aborts the refill.
        start_fill(32'h0a0);
        halt = 1'b1;
        #1;
        check("t4_halt_iREN", 32'(iREN), 32'd0);
        check("t4_halt_ihit", 32'(ihit), 32'd0);
        check("t4_halt_load", imemload, 32'd0);
        @(negedge CLK);
        #1;
        check("t4_halt_iREN2", 32'(iREN), 32'd0);
        @(negedge CLK);
        halt    = 1'b0;
        imemREN = 1'b0;
        acc_q.delete();
        fetch_check(32'h0a0, 5, "t4_refetch");
        check("t4_acc0", acc_q[0], 32'h0a0);

        // Reset mid-fill invalidates everything, including completed lines.
        fetch_check(32'h040, 0, "t5_pre_hit");
        start_fill(32'h0c0);
        RST = 1'b1;
        #1;
        check("t5_rst_iREN", 32'(iREN), 32'd0);
        check("t5_rst_iaddr", iaddr, 32'd0);
        @(negedge CLK);
        RST     = 1'b0;
        imemREN = 1'b0;
        fetch_check(32'h040, 5, "t5_miss040");
        fetch_check(32'h240, 5, "t5_miss240");
        fetch_check(32'h0c0, 5, "t5_miss0c0");

`ifdef ICACHE_STATS_EN
        @(negedge CLK);
        RST     = 1'b1;
        imemREN = 1'b0;
        @(negedge CLK);
        RST = 1'b0;
        fetch_check(32'h300, 5, "s_miss300");
        fetch_check(32'h304, 0, "s_hit304");
        fetch_check(32'h308, 5, "s_miss308");
        fetch_check(32'h30c, 0, "s_hit30c");
        fetch_check(32'h300, 0, "s_hit300");
        @(negedge CLK);
        imemREN = 1'b0;
        #1;
        check("s_hit_count", hit_count, 32'd5);
        check("s_miss_count", miss_count, 32'd2);
        @(negedge CLK);
        RST = 1'b1;
        @(negedge CLK);
        RST = 1'b0;
        #1;
        check("s_hit_clr", hit_count, 32'd0);
        check("s_miss_clr", miss_count, 32'd0);
`endif

        @(negedge CLK);
        imemREN = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/icache_assoc.md
Name: icache_assoc

Overview:
- Parametrised set-associative instruction cache between the datapath fetch port and the memory-controller instruction port.
- Generalises the direct-mapped, one-word-block icache to configurable sets, ways and words per block.
- Uses a multi-word refill state machine and round-robin replacement.
- Defers to data accesses and halts in the same way as the current icache.

Parameters:
SETS, 8, number of sets; power of two, at least 2
WAYS, 2, associativity; power of two, at least 1
WORDS, 2, 32-bit words per block; power of two, at least 1

Ports:
CLK  in  1  clock
RST  in  1  reset; one clock; reset is synchronous and active-high
imemREN  in  1  datapath fetch request
imemaddr  in  32  fetch byte address, word aligned
dmemREN  in  1  datapath data read pending; fetch deferred
dmemWEN  in  1  datapath data write pending; fetch deferred
halt  in  1  processor halted
ihit  out  1  fetch served this cycle
imemload  out  32  fetched instruction
iREN  out  1  memory read request
iaddr  out  32  memory word address
iload  in  32  memory read data
iwait  in  1  memory busy; word accepted when iREN && !iwait

Behaviour:
- Address split, low to high:
  - byte offset [1:0]
  - block offset: $clog2(WORDS) bits
  - index: $clog2(SETS) bits
  - tag: remainder
- Storage per set per way: valid, tag, WORDS data words. Per set: $clog2(WAYS)-bit replacement pointer.
- "req" means imemREN && !dmemREN && !dmemWEN && !halt.
- States: IDLE, FILL.
- IDLE:
  - req and a valid way's tag matches: ihit=1 and imemload=matching word, combinationally, same cycle; no memory traffic.
  - req and no match: latch block base address, choose victim, clear word counter, go to FILL; ihit=0 that cycle.
- Victim selection: lowest-index invalid way; otherwise the set's replacement pointer.
- FILL:
  - iREN=req and iaddr=latched base + 4*counter.
  - On each accepted word: store it into the victim buffer slot and increment the counter.
  - After word WORDS-1 is accepted: write tag, set valid, advance the set pointer by 1 mod WAYS, return to IDLE.
  - The hit is served the following cycle, so miss latency is WORDS accepted transfers + 1 cycle.
- FILL with dmemREN/dmemWEN high: iREN=0 and the counter holds; the fill resumes when they clear.
- FILL with imemaddr changed (branch): the fill completes for the latched block. The new address is looked up in IDLE afterwards.
- halt at any time: ihit=0, imemload=0, iREN=0. A FILL in progress aborts to IDLE and the victim line is left untouched (not made valid).
- imemload=0 whenever ihit=0.
- Reset (RST high at a clock edge): all valid bits 0, pointers 0, state IDLE, counter 0. A fill in progress is discarded.
- Output values during and after reset: ihit 0, imemload 0, iREN 0, iaddr 0.
- WAYS=1 degenerates to direct-mapped with no pointer. WORDS=1 gives single-transfer fills.

Optional Feature:
- Macro: ICACHE_STATS_EN.
- Defined:
  - adds outputs hit_count [31:0] and miss_count [31:0].
  - hit_count increments on every cycle with ihit=1.
  - miss_count increments on each IDLE to FILL transition.
  - Both counters clear on RST and wrap at 2^32.
- Undefined: the ports and counters are absent; all other behaviour is identical.

Decomposition:
- cpu_types_pkg gains:
  - icache_state_t enum {IDLE, FILL}
  - WORD_W=32
  - BYTE_OFF_W=2
- Widths derived from parameters stay local to icache_assoc.
- Sub-module icache_way, instantiated WAYS times:
  - contains one way's valid/tag/data arrays, the tag compare and a write port;
  - outputs hit and data for the addressed set.

Test Plan:
Defaults throughout. Memory returns data equal to address; iwait is high one cycle per word.
- Read at 0x040 after reset:
  - iREN with iaddr 0x040, then 0x044.
  - ihit on the cycle after the second word, with imemload 0x040.
  - Read at 0x044 then hits the same cycle with iREN=0.
- Conflict misses at index 0:
  - Fetch 0x040, 0x240, 0x440, 0x040.
  - 0x440 evicts 0x040 (way 0); the final 0x040 misses and evicts 0x240 (way 1).
  - 0x440 then hits.
- dmemWEN pulsed 3 cycles between fill words:
  - iREN low for those 3 cycles; iaddr resumes at 0x044.
  - The line completes correctly.
- halt mid-FILL after the first word:
  - iREN low next cycle.
  - After halt drops, 0x040 misses again and refetches from 0x040.
- RST mid-FILL, then after a completed fill:
  - All lines are invalid.
  - A previously cached 0x040 misses.
- With ICACHE_STATS_EN:
  - Two misses plus five hits give miss_count=2 and hit_count=5.
  - RST clears both counters.
